bcd2bin_seq: RTL



---
 rtl/bcd_pkg.sv | 27 ++
 rtl/bcd_digit_adj.sv | 20 ++
 rtl/bcd2bin_seq.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD <-> binary conversion blocks.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DIGIT_W    = 4;
    localparam int ADJ_THRESH = 8;
    localparam int ADJ_SUB    = 3;

    // True when bin_w bits can hold the largest n_digits-digit decimal
    // value (10^n - 1). The conversion also uses bin_w as its shift count.
    function automatic bit bin_w_sufficient(input int n_digits, input int bin_w);
        longint unsigned max_dec;
        max_dec = 64'd1;
        for (int i = 0; i < n_digits; i++) begin
            max_dec = max_dec * 64'd10;
        end
        return (max_dec - 64'd1) < (64'd1 << bin_w);
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Single-digit correction for reverse double-dabble: subtract 3 when the digit is >= 8.
// Latency: combinational.
// Backpressure: none (pure function of i_digit).
//
// Ports:
//   i_digit  in   DIGIT_W  digit after the right shift
//   o_digit  out  DIGIT_W  corrected digit
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_digit,
    output logic [DIGIT_W-1:0] o_digit
);

    // A digit >= 8 after the shift means a tens carry of 10 arrived as 8;
    // the -3 fixes that and can never underflow because the input is >= 8.
    assign o_digit = (i_digit >= DIGIT_W'(ADJ_THRESH)) ? (i_digit - DIGIT_W'(ADJ_SUB))
                                                       : i_digit;

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter, one reverse double-dabble shift per clock.
// Latency: start accepted at edge E0 -> done after edge E(BIN_W+1).
// Backpressure: start ignored while busy; a new start is accepted in the done cycle.
//
// Ports:
//   clk         in   1           rising-edge clock
//   rst_n       in   1           synchronous active-low reset
//   start       in   1           request, sampled only while busy=0
//   bcd_in      in   4*N_DIGITS  packed BCD operand, digit 0 in [3:0]
//   busy        out  1           conversion in progress
//   done        out  1           one-cycle completion pulse
//   binary_out  out  BIN_W       result, held until the next completion
//   err         out  1           invalid-digit flag, qualified by done
//
// Build option: define BCD2BIN_RANGE_CHECK_EN to reject operands containing a
// digit > 9 (done one cycle after acceptance, err=1, binary_out=0). Without it,
// err is tied low and invalid digits simply run through the algorithm.
module bcd2bin_seq
    import bcd_pkg::*;
#(
    parameter int N_DIGITS = 3,
    parameter int BIN_W    = 10
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [DIGIT_W*N_DIGITS-1:0]   bcd_in,
    output logic                          busy,
    output logic                          done,
    output logic [BIN_W-1:0]              binary_out,
    output logic                          err
);

    localparam int  BCD_W     = DIGIT_W * N_DIGITS;
    localparam int  CNT_W     = $clog2(BIN_W + 1);
    localparam bit  BIN_W_OK  = bin_w_sufficient(N_DIGITS, BIN_W);

    if (!BIN_W_OK) begin : g_bin_w_check
        $error("bcd2bin_seq: BIN_W too small for N_DIGITS decimal digits");
    end

    state_t             r_state, w_state_nxt;
    logic [BCD_W-1:0]   r_bcd, w_bcd_nxt;
    logic [BIN_W-1:0]   r_bin, w_bin_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_done, w_done_nxt;
    logic [BIN_W-1:0]   r_bin_out, w_bin_out_nxt;

    // Shift {bcd, bin} right by one, then correct every shifted digit.
    logic [BCD_W+BIN_W-1:0] w_cat_sh;
    logic [BCD_W-1:0]       w_bcd_sh;
    logic [BCD_W-1:0]       w_bcd_adj;
    logic [BIN_W-1:0]       w_bin_sh;

    assign w_cat_sh = {r_bcd, r_bin} >> 1;
    assign w_bcd_sh = w_cat_sh[BCD_W+BIN_W-1:BIN_W];
    assign w_bin_sh = w_cat_sh[BIN_W-1:0];

    for (genvar g = 0; g < N_DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .i_digit (w_bcd_sh[g*DIGIT_W +: DIGIT_W]),
            .o_digit (w_bcd_adj[g*DIGIT_W +: DIGIT_W])
        );
    end

`ifdef BCD2BIN_RANGE_CHECK_EN
    logic w_bad_digit;
    logic r_bad, w_bad_nxt;
    logic r_err, w_err_nxt;

    always_comb begin
        w_bad_digit = 1'b0;
        for (int d = 0; d < N_DIGITS; d++) begin
            if (bcd_in[d*DIGIT_W +: DIGIT_W] > DIGIT_W'(9)) begin
                w_bad_digit = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_bcd_nxt     = r_bcd;
        w_bin_nxt     = r_bin;
        w_cnt_nxt     = r_cnt;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_bin_out_nxt = r_bin_out;
`ifdef BCD2BIN_RANGE_CHECK_EN
        w_bad_nxt     = r_bad;
        w_err_nxt     = r_err;
`endif
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_bcd_nxt   = bcd_in;
                    w_bin_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = SHIFT;
`ifdef BCD2BIN_RANGE_CHECK_EN
                    // bin stays 0, so DONE publishes 0 for a rejected operand.
                    w_bad_nxt = w_bad_digit;
                    if (w_bad_digit) begin
                        w_state_nxt = DONE;
                    end
`endif
                end
            end
            SHIFT: begin
                w_bcd_nxt = w_bcd_adj;
                w_bin_nxt = w_bin_sh;
                w_cnt_nxt = r_cnt + CNT_W'(1);
                // r_cnt still holds the pre-increment count: this is shift BIN_W.
                if (r_cnt == CNT_W'(BIN_W - 1)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_bin_out_nxt = r_bin;
                w_done_nxt    = 1'b1;
                w_busy_nxt    = 1'b0;
                w_state_nxt   = IDLE;
`ifdef BCD2BIN_RANGE_CHECK_EN
                w_err_nxt     = r_bad;
`endif
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_bcd     <= '0;
            r_bin     <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_bin_out <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_bcd     <= w_bcd_nxt;
            r_bin     <= w_bin_nxt;
            r_cnt     <= w_cnt_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_bin_out <= w_bin_out_nxt;
        end
    end

`ifdef BCD2BIN_RANGE_CHECK_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bad <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_bad <= w_bad_nxt;
            r_err <= w_err_nxt;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign busy       = r_busy;
    assign done       = r_done;
    assign binary_out = r_bin_out;

endmodule
